// File: rtl/alu_seq.sv
// Registered add/sub/mul ALU with a start/busy/done handshake.
// Multiply is an iterative shift-add over W cycles into a 2W-bit accumulator.
//
// state | meaning
// IDLE  | waiting for start; r holds its last value
// MUL   | one shift-add iteration per cycle, W iterations
// FIN   | write r, pulse done (and err for an invalid op)
module alu_seq #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2:0]     f,
  output logic [2*W-1:0] r,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  state_t           state, state_nxt;
  logic             launch;
  logic [W-1:0]     bb;
  logic [2*W-1:0]   mcand;
  logic [W-1:0]     mplier;
  logic [2*W-1:0]   acc;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [W:0]       sum;
  logic [W:0]       diff;

  // f[0] swaps b for constant 1 only on add/sub; mul always uses b
  assign bb   = (f[0] && !f[2]) ? W'(1) : b;
  assign sum  = {1'b0, mcand[W-1:0]} + {1'b0, mplier};
  assign diff = {1'b0, mcand[W-1:0]} - {1'b0, mplier};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = (f[2:1] == OP_MUL) ? MUL : FIN;
        end
      end
      MUL: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      op_q   <= '0;
      r      <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            mcand  <= {{W{1'b0}}, a};
            mplier <= bb;
            op_q   <= f[2:1];
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        FIN: begin
          done <= 1'b1;
          case (op_q)
            OP_ADD: r <= {{(W-1){1'b0}}, sum};
            // borrow out of the W+1-bit difference is the sign bit
            OP_SUB: r <= {{W{diff[W]}}, diff[W-1:0]};
            OP_MUL: r <= acc;
            default: begin
              r   <= '0;
              err <= 1'b1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a W=4 instance for most scenarios and a W=8
// instance for the wide multiply.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [2:0]  f4, f8;
  logic [7:0]  r4;
  logic [15:0] r8;
  logic        busy4, done4, err4;
  logic        busy8, done8, err8;

  int n_tests;
  int n_fail;

  alu_seq #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .f(f4),
    .r(r4), .busy(busy4), .done(done4), .err(err4)
  );

  alu_seq #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .f(f8),
    .r(r8), .busy(busy8), .done(done8), .err(err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one op on the W=4 instance, then waits (bounded) for done.
  // lat counts cycles from the start edge; ends 1 time unit into the done cycle.
  task automatic run_op4(input logic [3:0] ta, input logic [3:0] tb,
                         input logic [2:0] tf, output int lat, output int bc);
    @(posedge clk); #1;
    a4 = ta; b4 = tb; f4 = tf; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 1;
    bc  = 0;
    while (!done4 && lat < 40) begin
      if (busy4) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (r4 !== 8'h00) begin n_fail++; $display("FAIL reset_r got=%h exp=00", r4); end
    n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy4); end
    n_tests++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done4); end
    n_tests++; if (err4 !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err4); end
    n_tests++; if (r8 !== 16'h0000) begin n_fail++; $display("FAIL reset_r8 got=%h exp=0000", r8); end
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    int lat, bc;
    run_op4(4'd7, 4'd9, 3'b000, lat, bc);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL add_lat got=%0d exp=2", lat); end
    n_tests++; if (bc !== 1) begin n_fail++; $display("FAIL add_busy got=%0d exp=1", bc); end
    n_tests++; if (r4 !== 8'h10) begin n_fail++; $display("FAIL add_r got=%h exp=10", r4); end
    n_tests++; if (err4 !== 1'b0) begin n_fail++; $display("FAIL add_err got=%b exp=0", err4); end
    @(posedge clk); #1;
    n_tests++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse got=%b exp=0", done4); end
    run_op4(4'd15, 4'd3, 3'b001, lat, bc);
    n_tests++; if (r4 !== 8'h10) begin n_fail++; $display("FAIL inc_r got=%h exp=10", r4); end
  endtask

  task automatic test_sub;
    int lat, bc;
    run_op4(4'd3, 4'd5, 3'b010, lat, bc);
    n_tests++; if (r4 !== 8'hFE) begin n_fail++; $display("FAIL sub_borrow_r got=%h exp=fe", r4); end
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL sub_lat got=%0d exp=2", lat); end
    run_op4(4'd0, 4'd9, 3'b011, lat, bc);
    n_tests++; if (r4 !== 8'hFF) begin n_fail++; $display("FAIL dec_r got=%h exp=ff", r4); end
    run_op4(4'd9, 4'd4, 3'b010, lat, bc);
    n_tests++; if (r4 !== 8'h05) begin n_fail++; $display("FAIL sub_r got=%h exp=05", r4); end
  endtask

  task automatic test_mul;
    int lat, bc;
    @(posedge clk); #1;
    a4 = 4'd15; b4 = 4'd15; f4 = 3'b100; start4 = 1'b1;
    @(posedge clk); #1;
    // start stays high and operands change while busy: must be ignored
    a4 = 4'd2; b4 = 4'd3;
    lat = 1;
    bc  = 0;
    while (!done4 && lat < 40) begin
      if (busy4) bc++;
      if (lat == 4) start4 = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start4 = 1'b0;
    n_tests++; if (bc !== 5) begin n_fail++; $display("FAIL mul_busy got=%0d exp=5", bc); end
    n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL mul_lat got=%0d exp=6", lat); end
    n_tests++; if (r4 !== 8'hE1) begin n_fail++; $display("FAIL mul_r got=%h exp=e1", r4); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL mul_not_queued got=%b exp=0", busy4); end
    n_tests++; if (r4 !== 8'hE1) begin n_fail++; $display("FAIL mul_r_hold got=%h exp=e1", r4); end
  endtask

  task automatic test_mul_w8;
    int lat, bc;
    @(posedge clk); #1;
    a8 = 8'd255; b8 = 8'd255; f8 = 3'b101; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    bc  = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bc++;
      @(posedge clk); #1;
      lat++;
    end
    n_tests++; if (lat !== 10) begin n_fail++; $display("FAIL mul8_lat got=%0d exp=10", lat); end
    n_tests++; if (bc !== 9) begin n_fail++; $display("FAIL mul8_busy got=%0d exp=9", bc); end
    n_tests++; if (r8 !== 16'hFE01) begin n_fail++; $display("FAIL mul8_r got=%h exp=fe01", r8); end
  endtask

  task automatic test_invalid;
    int lat, bc;
    run_op4(4'd6, 4'd6, 3'b110, lat, bc);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL inv_lat got=%0d exp=2", lat); end
    n_tests++; if (err4 !== 1'b1) begin n_fail++; $display("FAIL inv_err got=%b exp=1", err4); end
    n_tests++; if (r4 !== 8'h00) begin n_fail++; $display("FAIL inv_r got=%h exp=00", r4); end
    @(posedge clk); #1;
    n_tests++; if (err4 !== 1'b0) begin n_fail++; $display("FAIL inv_err_clear got=%b exp=0", err4); end
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (r4 !== 8'h00) begin n_fail++; $display("FAIL inv_r_hold got=%h exp=00", r4); end
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    int seen_done;
    run_op4(4'd5, 4'd4, 3'b000, lat, bc);
    n_tests++; if (r4 !== 8'h09) begin n_fail++; $display("FAIL pre_rst_r got=%h exp=09", r4); end
    @(posedge clk); #1;
    a4 = 4'd13; b4 = 4'd11; f4 = 3'b100; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    seen_done = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy4); end
    n_tests++; if (r4 !== 8'h00) begin n_fail++; $display("FAIL rst_mid_r got=%h exp=00", r4); end
    for (int i = 0; i < 8; i++) begin
      if (done4) seen_done++;
      @(posedge clk); #1;
    end
    n_tests++; if (seen_done !== 0) begin n_fail++; $display("FAIL rst_mid_no_done got=%0d exp=0", seen_done); end
    run_op4(4'd13, 4'd11, 3'b100, lat, bc);
    n_tests++; if (r4 !== 8'h8F) begin n_fail++; $display("FAIL rst_mid_fresh_r got=%h exp=8f", r4); end
    n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL rst_mid_fresh_lat got=%0d exp=6", lat); end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(posedge clk); #1;
    a4 = 4'd1; b4 = 4'd2; f4 = 3'b000; start4 = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!done4 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++; if (r4 !== 8'h03) begin n_fail++; $display("FAIL b2b_first_r got=%h exp=03", r4); end
    // new operand is picked up by the relaunch at the end of this done cycle
    a4 = 4'd5;
    @(posedge clk); #1;
    n_tests++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL b2b_relaunch got=%b exp=1", busy4); end
    start4 = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (done4 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got=%b exp=1", done4); end
    n_tests++; if (r4 !== 8'h07) begin n_fail++; $display("FAIL b2b_second_r got=%h exp=07", r4); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start4  = 1'b0; a4 = '0; b4 = '0; f4 = '0;
    start8  = 1'b0; a8 = '0; b8 = '0; f8 = '0;
    test_reset;
    test_add;
    test_sub;
    test_mul;
    test_mul_w8;
    test_invalid;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
